// File: rtl/mc_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_controller_pkg
//  Purpose  : Shared encodings for the multi-cycle MIPS-subset control path:
//             opcode/funct values, ALU op codes, FSM state codes, datapath
//             mux-select codes and the ALU-op class used by alu_op_decoder.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mc_controller_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;

  // FSM state encodings; codes 14 and 15 are unused and recover to FETCH
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_LW_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_I_WB     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_JR       = 4'd13;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_AREG   = 2'b11;

  // Register-file destination select
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_AREG = 2'b01;
  localparam logic [1:0] SRC_A_BREG = 2'b10;

  // ALU operand B select
  localparam logic [2:0] SRC_B_BREG   = 3'b000;
  localparam logic [2:0] SRC_B_FOUR   = 3'b001;
  localparam logic [2:0] SRC_B_IMM    = 3'b010;
  localparam logic [2:0] SRC_B_IMM_S2 = 3'b011;
  localparam logic [2:0] SRC_B_SHAMT  = 3'b100;

  // How the ALU op is chosen for the current step
  typedef enum logic [1:0] {
    CLS_ADD   = 2'b00,
    CLS_SUB   = 2'b01,
    CLS_FUNCT = 2'b10,
    CLS_IMM   = 2'b11
  } aluop_class_e;

  // True for the R-type functions executed through EXEC_R (jr excluded)
  function automatic logic is_exec_r_funct(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT) || (fn == FN_SLL);
  endfunction

endpackage : mc_controller_pkg
`default_nettype wire

// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_controller_if
//  Purpose  : Bundle of instruction-field inputs and datapath control outputs
//             between the control FSM and the datapath.
//  Ports    : none; modport master = controller side, slave = datapath side.
//             opcode[5:0], funct[5:0], zero       datapath -> controller
//             alu_op[2:0], pc_en, pc_src[1:0], iord, mem_read, mem_write,
//             ir_write, reg_write, reg_dst[1:0], mem_to_reg[1:0],
//             alu_src_a[1:0], alu_src_b[2:0], ext_zero, instr_done, illegal
//                                                 controller -> datapath
//  Revision : 1.0 - initial release
// ============================================================================
interface mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic [2:0] alu_op;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic       ext_zero;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct, zero,
    output alu_op, pc_en, pc_src, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero,
           instr_done, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  alu_op, pc_en, pc_src, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero,
           instr_done, illegal
  );
endinterface : mc_controller_if
`default_nettype wire

// File: rtl/mc_controller_alu_op_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decoder
//  Purpose  : Combinational ALU-op selection. The FSM supplies a class
//             (fixed add, fixed sub, from funct, from I-type opcode) and this
//             block resolves it to the 3-bit ALU op.
//  Ports    : i_class[1:0]  ALU-op class
//             i_opcode[5:0] IR[31:26]
//             i_funct[5:0]  IR[5:0]
//             o_alu_op[2:0] ALU operation
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_decoder
  import mc_controller_pkg::*;
(
  input  aluop_class_e i_class,
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  output logic [2:0]   o_alu_op
);

  always_comb begin
    o_alu_op = ALU_ADD;
    case (i_class)
      CLS_ADD: o_alu_op = ALU_ADD;
      CLS_SUB: o_alu_op = ALU_SUB;
      CLS_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_op = ALU_ADD;
          FN_SUB:  o_alu_op = ALU_SUB;
          FN_AND:  o_alu_op = ALU_AND;
          FN_OR:   o_alu_op = ALU_OR;
          FN_SLT:  o_alu_op = ALU_SLT;
          FN_SLL:  o_alu_op = ALU_SLL;
          default: o_alu_op = ALU_ADD;
        endcase
      end
      CLS_IMM: begin
        case (i_opcode)
          OP_ADDI: o_alu_op = ALU_ADD;
          OP_SLTI: o_alu_op = ALU_SLT;
          OP_ANDI: o_alu_op = ALU_AND;
          OP_ORI:  o_alu_op = ALU_OR;
          default: o_alu_op = ALU_ADD;
        endcase
      end
      default: o_alu_op = ALU_ADD;
    endcase
  end

endmodule : alu_op_decoder
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mc_controller
//  Purpose  : Multi-cycle control FSM for the 32-bit MIPS-subset datapath.
//             Decodes opcode/funct, steps the datapath one state per cycle,
//             drives the ALU op, uses the ALU zero flag for beq, and pulses
//             instr_done in the last state of every instruction.
//  Ports    : clk   rising-edge clock
//             rst   asynchronous active-high reset
//             ctrl  mc_controller_if.master (instruction fields in,
//                   datapath controls out)
//  Revision : 1.0 - initial release
// ============================================================================
module mc_controller
  import mc_controller_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst,
  mc_controller_if.master ctrl
);

  logic [3:0]   r_state;
  logic [3:0]   w_next_state;
  logic         w_decode_illegal;

  aluop_class_e w_alu_class;
  logic [2:0]   w_alu_op;
  logic         w_pc_write;
  logic [1:0]   w_pc_src;
  logic         w_iord;
  logic         w_mem_read;
  logic         w_mem_write;
  logic         w_ir_write;
  logic         w_reg_write;
  logic [1:0]   w_reg_dst;
  logic [1:0]   w_mem_to_reg;
  logic [1:0]   w_src_a;
  logic [2:0]   w_src_b;
  logic         w_ext_zero;
  logic         w_done;
  logic         w_is_sll;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Terminal states and unused codes all return to FETCH.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state     = S_FETCH;
    w_decode_illegal = 1'b0;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (ctrl.opcode)
          OP_RTYPE: begin
            if (ctrl.funct == FN_JR) begin
              w_next_state = S_JR;
            end else if (is_exec_r_funct(ctrl.funct)) begin
              w_next_state = S_EXEC_R;
            end else begin
              w_decode_illegal = 1'b1;
            end
          end
          OP_LW, OP_SW:                      w_next_state = S_MEM_ADDR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next_state = S_EXEC_I;
          OP_BEQ:                            w_next_state = S_BRANCH;
          OP_J:                              w_next_state = S_JUMP;
          OP_JAL:                            w_next_state = S_JAL;
          default:                           w_decode_illegal = 1'b1;
        endcase
      end
      // IR is stable for the whole instruction, so the opcode still
      // distinguishes lw from sw here.
      S_MEM_ADDR: w_next_state = (ctrl.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next_state = S_LW_WB;
      S_EXEC_R:   w_next_state = S_R_WB;
      S_EXEC_I:   w_next_state = S_I_WB;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Moore output decode (EXEC_R / EXEC_I additionally look at funct/opcode)
  // --------------------------------------------------------------------------
  assign w_is_sll = (ctrl.funct == FN_SLL);

  always_comb begin
    w_alu_class  = CLS_ADD;
    w_pc_write   = 1'b0;
    w_pc_src     = PC_SRC_ALU;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = REG_DST_RT;
    w_mem_to_reg = M2R_ALUOUT;
    w_src_a      = SRC_A_PC;
    w_src_b      = SRC_B_BREG;
    w_ext_zero   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = 1'b1;
        w_src_a    = SRC_A_PC;
        w_src_b    = SRC_B_FOUR;
        w_pc_src   = PC_SRC_ALU;
        w_pc_write = 1'b1;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut
        w_src_a = SRC_A_PC;
        w_src_b = SRC_B_IMM_S2;
      end
      S_MEM_ADDR: begin
        w_src_a = SRC_A_AREG;
        w_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
      end
      S_LW_WB: begin
        w_reg_dst    = REG_DST_RT;
        w_mem_to_reg = M2R_MDR;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      S_MEM_WR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        w_done      = 1'b1;
      end
      S_EXEC_R: begin
        // sll shifts rt (B reg) by shamt instead of combining A and B
        w_alu_class = CLS_FUNCT;
        w_src_a     = w_is_sll ? SRC_A_BREG  : SRC_A_AREG;
        w_src_b     = w_is_sll ? SRC_B_SHAMT : SRC_B_BREG;
      end
      S_R_WB: begin
        w_reg_dst    = REG_DST_RD;
        w_mem_to_reg = M2R_ALUOUT;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      S_EXEC_I: begin
        w_alu_class = CLS_IMM;
        w_src_a     = SRC_A_AREG;
        w_src_b     = SRC_B_IMM;
        w_ext_zero  = (ctrl.opcode == OP_ANDI) || (ctrl.opcode == OP_ORI);
      end
      S_I_WB: begin
        w_reg_dst    = REG_DST_RT;
        w_mem_to_reg = M2R_ALUOUT;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      S_BRANCH: begin
        w_alu_class = CLS_SUB;
        w_src_a     = SRC_A_AREG;
        w_src_b     = SRC_B_BREG;
        w_pc_src    = PC_SRC_ALUOUT;
        w_done      = 1'b1;
      end
      S_JUMP: begin
        w_pc_src   = PC_SRC_JUMP;
        w_pc_write = 1'b1;
        w_done     = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, which is the link value
        w_pc_src     = PC_SRC_JUMP;
        w_pc_write   = 1'b1;
        w_reg_dst    = REG_DST_RA;
        w_mem_to_reg = M2R_PC;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      S_JR: begin
        w_pc_src   = PC_SRC_AREG;
        w_pc_write = 1'b1;
        w_done     = 1'b1;
      end
      default: begin
        w_alu_class = CLS_ADD;
      end
    endcase
  end

  alu_op_decoder u_alu_op_decoder (
    .i_class  (w_alu_class),
    .i_opcode (ctrl.opcode),
    .i_funct  (ctrl.funct),
    .o_alu_op (w_alu_op)
  );

  // --------------------------------------------------------------------------
  // Output drive. Everything is held low while rst is high so that an
  // abandoned instruction cannot write the register file, memory or PC.
  // --------------------------------------------------------------------------
  assign ctrl.alu_op     = rst ? 3'b000 : w_alu_op;
  assign ctrl.pc_en      = ~rst & (w_pc_write | ((r_state == S_BRANCH) & ctrl.zero));
  assign ctrl.pc_src     = rst ? 2'b00 : w_pc_src;
  assign ctrl.iord       = ~rst & w_iord;
  assign ctrl.mem_read   = ~rst & w_mem_read;
  assign ctrl.mem_write  = ~rst & w_mem_write;
  assign ctrl.ir_write   = ~rst & w_ir_write;
  assign ctrl.reg_write  = ~rst & w_reg_write;
  assign ctrl.reg_dst    = rst ? 2'b00 : w_reg_dst;
  assign ctrl.mem_to_reg = rst ? 2'b00 : w_mem_to_reg;
  assign ctrl.alu_src_a  = rst ? 2'b00 : w_src_a;
  assign ctrl.alu_src_b  = rst ? 3'b000 : w_src_b;
  assign ctrl.ext_zero   = ~rst & w_ext_zero;
  assign ctrl.instr_done = ~rst & w_done;
  assign ctrl.illegal    = ~rst & w_decode_illegal;

endmodule : mc_controller
`default_nettype wire
